mem_arbiter_2p: RTL and testbench

- Two-port arbiter that shares the single main-memory port (native valid/ready/addr/wdata/wstrb/rdata interface) between two requesters: port 0 = instruction cache refill side, port 1 = data cache refill/write-through side.
- Sits between the split L1 caches and the memory model.
- Round-robin arbitration with optional burst lock so a cache line refill of BURST_MAX words completes without interleaving.
- Saturating per-port transaction counters for performance analysis.

---
 rtl/mem_arb_pkg.sv | 27 ++
 rtl/mem_arbiter_2p_sat_counter.sv | 29 ++
 rtl/mem_arbiter_2p.sv | 194 +++++++++++++++++++
 tb/tb_mem_arbiter_2p.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// ---------------------------------------------------------------------------
// mem_arb_pkg
// Shared constants for the two-port memory arbiter: FSM state encoding,
// requester port indices and one-hot grant codes.
// ---------------------------------------------------------------------------
package mem_arb_pkg;

    // FSM state encoding (kept as plain constants for legacy tool flows)
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_OWN0 = 2'd1;
    localparam logic [1:0] ST_OWN1 = 2'd2;

    // Requester port indices
    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

    // One-hot grant codes
    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_P0   = 2'b01;
    localparam logic [1:0] GNT_P1   = 2'b10;

    // Ownership state for a given port index
    function automatic logic [1:0] own_state(input logic port);
        return (port == PORT1) ? ST_OWN1 : ST_OWN0;
    endfunction

endpackage

// File: rtl/mem_arbiter_2p_sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
// Up-counter that sticks at all ones instead of wrapping.
//   clk, resetn : clock, asynchronous active-low reset
//   inc         : count one event this cycle
//   count       : current value, saturating at 2**WIDTH-1
// ---------------------------------------------------------------------------
module sat_counter #(
    parameter int WIDTH = 21
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_count <= '0;
        end else if (inc && (r_count != '1)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;

endmodule

// File: rtl/mem_arbiter_2p.sv
// ---------------------------------------------------------------------------
// mem_arbiter_2p
// Shares one native valid/ready memory port between two requesters
// (port 0 = I-cache refill, port 1 = D-cache refill / write-through).
// Round-robin between ports, with an optional lock that lets the owner keep
// the port for up to BURST_MAX back-to-back transfers.
//
//   state | meaning
//   IDLE  | no owner; arbitrate among valid requests
//   OWN0  | port 0 drives the memory port
//   OWN1  | port 1 drives the memory port
//
// Ports:
//   clk, resetn              : clock, asynchronous active-low reset
//   mX_valid/lock/addr/wdata/wstrb : requester X request (wstrb 0 = read)
//   mX_ready, mX_rdata       : requester X completion / read data
//   s_valid/addr/wdata/wstrb : request towards memory
//   s_ready, s_rdata         : memory completion / read data
//   grant                    : one-hot owner, 00 when idle
//   cnt0, cnt1               : saturating completed-transfer counts
// ---------------------------------------------------------------------------
module mem_arbiter_2p
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int BURST_MAX = 8,
    parameter int CNT_W     = 21
) (
    input  logic                clk,
    input  logic                resetn,

    input  logic                m0_valid,
    input  logic                m0_lock,
    input  logic [ADDR_W-1:0]   m0_addr,
    input  logic [DATA_W-1:0]   m0_wdata,
    input  logic [DATA_W/8-1:0] m0_wstrb,
    output logic                m0_ready,
    output logic [DATA_W-1:0]   m0_rdata,

    input  logic                m1_valid,
    input  logic                m1_lock,
    input  logic [ADDR_W-1:0]   m1_addr,
    input  logic [DATA_W-1:0]   m1_wdata,
    input  logic [DATA_W/8-1:0] m1_wstrb,
    output logic                m1_ready,
    output logic [DATA_W-1:0]   m1_rdata,

    output logic                s_valid,
    output logic [ADDR_W-1:0]   s_addr,
    output logic [DATA_W-1:0]   s_wdata,
    output logic [DATA_W/8-1:0] s_wstrb,
    input  logic                s_ready,
    input  logic [DATA_W-1:0]   s_rdata,

    output logic [1:0]          grant,
    output logic [CNT_W-1:0]    cnt0,
    output logic [CNT_W-1:0]    cnt1
);

    localparam int BURST_W = $clog2(BURST_MAX) + 1;
    localparam logic [BURST_W-1:0] LP_BURST_MAX = BURST_W'(BURST_MAX);

    logic [1:0]         r_state;
    logic [BURST_W-1:0] r_burst;
    // Port that wins when both request from IDLE. This is the inverse of
    // "last served": reset to 0 so port 0 goes first after reset, and set
    // to the other port whenever a transfer completes.
    logic               r_pref;

    logic [1:0]         w_state_nxt;
    logic [BURST_W-1:0] w_burst_nxt;
    logic               w_pref_nxt;

    logic               w_owned;
    logic               w_owner;
    logic               w_own_valid;
    logic               w_own_lock;
    logic               w_other_valid;
    logic               w_done;
    logic [BURST_W-1:0] w_burst_inc;

    assign w_owned       = (r_state == ST_OWN0) || (r_state == ST_OWN1);
    assign w_owner       = (r_state == ST_OWN1) ? PORT1 : PORT0;
    assign w_own_valid   = (w_owner == PORT1) ? m1_valid : m0_valid;
    assign w_own_lock    = (w_owner == PORT1) ? m1_lock  : m0_lock;
    assign w_other_valid = (w_owner == PORT1) ? m0_valid : m1_valid;
    assign w_done        = w_owned && s_ready;
    assign w_burst_inc   = r_burst + 1'b1;

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        w_burst_nxt = r_burst;
        w_pref_nxt  = r_pref;
        case (r_state)
            ST_IDLE: begin
                // s_ready is ignored here; nothing is outstanding
                if (m0_valid && m1_valid) begin
                    w_state_nxt = own_state(r_pref);
                end else if (m0_valid) begin
                    w_state_nxt = ST_OWN0;
                end else if (m1_valid) begin
                    w_state_nxt = ST_OWN1;
                end
            end
            ST_OWN0, ST_OWN1: begin
                if (s_ready) begin
                    // Completion takes priority over the owner's valid: the
                    // requester still holds valid in this cycle.
                    w_pref_nxt = ~w_owner;
                    if (w_own_lock && (w_burst_inc < LP_BURST_MAX)) begin
                        w_burst_nxt = w_burst_inc;
                    end else begin
                        w_burst_nxt = '0;
                        w_state_nxt = w_other_valid ? own_state(~w_owner) : ST_IDLE;
                    end
                end else if (!w_own_valid) begin
                    // Owner withdrew its request before memory answered
                    w_burst_nxt = '0;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_burst_nxt = '0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
            r_burst <= '0;
            r_pref  <= PORT0;
        end else begin
            r_state <= w_state_nxt;
            r_burst <= w_burst_nxt;
            r_pref  <= w_pref_nxt;
        end
    end

    // Request/response muxing, purely from the registered owner so that an
    // async reset clears every output immediately.
    always_comb begin
        s_valid  = 1'b0;
        s_addr   = '0;
        s_wdata  = '0;
        s_wstrb  = '0;
        m0_ready = 1'b0;
        m0_rdata = '0;
        m1_ready = 1'b0;
        m1_rdata = '0;
        grant    = GNT_NONE;
        case (r_state)
            ST_OWN0: begin
                s_valid  = m0_valid;
                s_addr   = m0_addr;
                s_wdata  = m0_wdata;
                s_wstrb  = m0_wstrb;
                m0_ready = s_ready;
                m0_rdata = s_rdata;
                grant    = GNT_P0;
            end
            ST_OWN1: begin
                s_valid  = m1_valid;
                s_addr   = m1_addr;
                s_wdata  = m1_wdata;
                s_wstrb  = m1_wstrb;
                m1_ready = s_ready;
                m1_rdata = s_rdata;
                grant    = GNT_P1;
            end
            default: begin
                grant = GNT_NONE;
            end
        endcase
    end

    sat_counter #(.WIDTH(CNT_W)) u_cnt0 (
        .clk    (clk),
        .resetn (resetn),
        .inc    (w_done && (w_owner == PORT0)),
        .count  (cnt0)
    );

    sat_counter #(.WIDTH(CNT_W)) u_cnt1 (
        .clk    (clk),
        .resetn (resetn),
        .inc    (w_done && (w_owner == PORT1)),
        .count  (cnt1)
    );

endmodule

// File: tb/tb_mem_arbiter_2p.sv
module tb_mem_arbiter_2p;

    localparam int ADDR_W    = 32;
    localparam int DATA_W    = 32;
    localparam int STRB_W    = DATA_W / 8;
    localparam int BURST_MAX = 8;
    localparam int CNT_W     = 4;
    localparam int CNT_MAX   = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    logic              v  [2];
    logic              lk [2];
    logic [ADDR_W-1:0] ad [2];
    logic [DATA_W-1:0] wd [2];
    logic [STRB_W-1:0] ws [2];
    logic              s_ready;
    logic [DATA_W-1:0] s_rdata;

    logic              m0_valid, m0_lock, m1_valid, m1_lock;
    logic [ADDR_W-1:0] m0_addr, m1_addr;
    logic [DATA_W-1:0] m0_wdata, m1_wdata;
    logic [STRB_W-1:0] m0_wstrb, m1_wstrb;
    logic              m0_ready, m1_ready, s_valid;
    logic [DATA_W-1:0] m0_rdata, m1_rdata, s_wdata;
    logic [ADDR_W-1:0] s_addr;
    logic [STRB_W-1:0] s_wstrb;
    logic [1:0]        grant;
    logic [CNT_W-1:0]  cnt0, cnt1;

    assign m0_valid = v[0];  assign m1_valid = v[1];
    assign m0_lock  = lk[0]; assign m1_lock  = lk[1];
    assign m0_addr  = ad[0]; assign m1_addr  = ad[1];
    assign m0_wdata = wd[0]; assign m1_wdata = wd[1];
    assign m0_wstrb = ws[0]; assign m1_wstrb = ws[1];

    mem_arbiter_2p #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_MAX(BURST_MAX), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .resetn(resetn),
        .m0_valid(m0_valid), .m0_lock(m0_lock), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb), .m0_ready(m0_ready), .m0_rdata(m0_rdata),
        .m1_valid(m1_valid), .m1_lock(m1_lock), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_ready(m1_ready), .m1_rdata(m1_rdata),
        .s_valid(s_valid), .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .s_ready(s_ready), .s_rdata(s_rdata),
        .grant(grant), .cnt0(cnt0), .cnt1(cnt1)
    );

    // Reference model: who owns the memory port (-1 = nobody), which port
    // wins a tie, how many transfers the owner has done in this grant, and
    // completed-transfer totals.
    int own;
    int pref;
    int burst;
    int cnt [2];
    bit done [2];

    int total  = 0;
    int passed = 0;
    int fails  = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic exp_svalid();
        return (own >= 0) ? v[own] : 1'b0;
    endfunction

    task automatic model_reset();
        own = -1; pref = 0; burst = 0;
        cnt[0] = 0; cnt[1] = 0;
        done[0] = 0; done[1] = 0;
    endtask

    task automatic check_outputs();
        logic [1:0]        eg;
        logic [ADDR_W-1:0] ea;
        logic [DATA_W-1:0] ewd;
        logic [STRB_W-1:0] ews;
        eg = (own == 0) ? 2'b01 : (own == 1) ? 2'b10 : 2'b00;
        ea = '0; ewd = '0; ews = '0;
        if (own >= 0) begin
            ea = ad[own]; ewd = wd[own]; ews = ws[own];
        end
        chk("grant",    grant,    eg);
        chk("s_valid",  s_valid,  exp_svalid());
        chk("s_addr",   s_addr,   ea);
        chk("s_wdata",  s_wdata,  ewd);
        chk("s_wstrb",  s_wstrb,  ews);
        chk("m0_ready", m0_ready, (own == 0) ? s_ready : 1'b0);
        chk("m1_ready", m1_ready, (own == 1) ? s_ready : 1'b0);
        chk("m0_rdata", m0_rdata, (own == 0) ? s_rdata : '0);
        chk("m1_rdata", m1_rdata, (own == 1) ? s_rdata : '0);
        chk("cnt0",     cnt0,     cnt[0]);
        chk("cnt1",     cnt1,     cnt[1]);
    endtask

    // Applies the arbitration rules for one rising edge using the inputs
    // that were held during the cycle.
    task automatic model_clock();
        int x, o;
        done[0] = 0; done[1] = 0;
        if (!resetn) begin
            model_reset();
        end else if (own < 0) begin
            if (v[0] && v[1]) own = pref;
            else if (v[0])    own = 0;
            else if (v[1])    own = 1;
        end else begin
            x = own; o = 1 - own;
            if (s_ready) begin
                done[x] = 1;
                pref = o;
                if (cnt[x] < CNT_MAX) cnt[x]++;
                burst++;
                if (!(lk[x] && burst < BURST_MAX)) begin
                    burst = 0;
                    own = v[o] ? o : -1;
                end
            end else if (!v[x]) begin
                own = -1;
                burst = 0;
            end
        end
    endtask

    task automatic step();
        #1 check_outputs();
        @(posedge clk);
        model_clock();
        @(negedge clk);
    endtask

    task automatic apply_reset();
        resetn = 1'b0;
        #1;
        model_reset();
        check_outputs();
        @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic new_tx(input int p);
        v[p]  = 1'b1;
        lk[p] = 1'($urandom_range(1, 0));
        ad[p] = $urandom;
        wd[p] = $urandom;
        ws[p] = STRB_W'($urandom_range(15, 0));
    endtask

    initial begin
        int rem [2];
        int k, n;
        for (int p = 0; p < 2; p++) begin
            v[p] = 1'b0; lk[p] = 1'b0; ad[p] = '0; wd[p] = '0; ws[p] = '0;
        end
        s_ready = 1'b0;
        s_rdata = 32'h1234_5678;
        model_reset();

        // Reset with both requesters active and memory ready: nothing granted
        v[0] = 1'b1; v[1] = 1'b1; s_ready = 1'b1;
        apply_reset();
        chk("rst_grant", grant, 2'b00);
        chk("rst_svalid", s_valid, 1'b0);

        // Single port-0 read: grant one cycle after valid, ready after 2 cycles
        v[1] = 1'b0; s_ready = 1'b0; ad[0] = 32'h40;
        step();
        chk("t1_grant", grant, 2'b01);
        step();
        s_ready = 1'b1; s_rdata = 32'hCAFE_0001;
        step();
        v[0] = 1'b0; s_ready = 1'b0;
        step();
        chk("t1_cnt0", cnt0, 4'd1);

        // Both unlocked, memory always ready: strict alternation from port 0
        apply_reset();
        rem[0] = 6; rem[1] = 6; k = 0;
        new_tx(0); new_tx(1); lk[0] = 1'b0; lk[1] = 1'b0;
        for (int c = 0; c < 40 && (rem[0] > 0 || rem[1] > 0); c++) begin
            s_ready = exp_svalid();
            s_rdata = $urandom;
            step();
            for (int p = 0; p < 2; p++) begin
                if (done[p]) begin
                    chk("t2_order", p, k % 2);
                    k++;
                    rem[p]--;
                    if (rem[p] == 0) v[p] = 1'b0;
                    else begin new_tx(p); lk[p] = 1'b0; end
                end
            end
        end
        s_ready = 1'b0;
        step();
        chk("t2_cnt0", cnt0, 4'd6);
        chk("t2_cnt1", cnt1, 4'd6);

        // Port 1 locked burst while port 0 waits
        apply_reset();
        v[1] = 1'b1; lk[1] = 1'b1; ad[1] = 32'h2000;
        step();
        v[0] = 1'b1; lk[0] = 1'b0; ad[0] = 32'h3000;
        for (int c = 0; c < BURST_MAX; c++) begin
            s_ready = 1'b1;
            ad[1] = 32'h2000 + 32'(c * 4);
            step();
            chk("t3_burst", done[1], 1'b1);
        end
        #1 chk("t3_handover", grant, 2'b01);
        s_ready = 1'b1; v[1] = 1'b0;
        step();
        v[0] = 1'b0; s_ready = 1'b0;
        step();
        chk("t3_cnt1", cnt1, BURST_MAX);

        // Write from port 0 passes through untouched
        apply_reset();
        v[0] = 1'b1; lk[0] = 1'b0; ad[0] = 32'h100; wd[0] = 32'hDEADBEEF; ws[0] = 4'b0011;
        step();
        #1;
        chk("t4_addr", s_addr, 32'h100);
        chk("t4_wdata", s_wdata, 32'hDEADBEEF);
        chk("t4_wstrb", s_wstrb, 4'b0011);
        s_ready = 1'b1;
        step();
        v[0] = 1'b0; s_ready = 1'b0;
        step();

        // Abort: owner drops valid before memory answers
        v[0] = 1'b1;
        step();
        step();
        v[0] = 1'b0;
        step();
        step();
        chk("t5_cnt0", cnt0, 4'd1);

        // Async reset in the middle of a port-1 transfer
        v[1] = 1'b1; lk[1] = 1'b0; ad[1] = 32'h5000;
        step();
        step();
        s_ready = 1'b1;
        #1 chk("t5_m1_ready_pre", m1_ready, 1'b1);
        resetn = 1'b0;
        #1;
        model_reset();
        chk("t5_m1_ready_rst", m1_ready, 1'b0);
        chk("t5_grant_rst", grant, 2'b00);
        chk("t5_svalid_rst", s_valid, 1'b0);
        check_outputs();
        @(negedge clk);
        resetn = 1'b1; v[1] = 1'b0; s_ready = 1'b0;
        step();
        step();

        // Counter saturation with a narrow counter
        apply_reset();
        v[0] = 1'b1; lk[0] = 1'b0; n = 0;
        for (int c = 0; c < 60 && n < 18; c++) begin
            s_ready = exp_svalid();
            lk[0] = 1'($urandom_range(1, 0));
            step();
            if (done[0]) begin
                n++;
                #1 chk("t6_sat", cnt0, (n < CNT_MAX) ? n : CNT_MAX);
            end
        end
        chk("t6_count", n, 18);
        v[0] = 1'b0; s_ready = 1'b0;
        step();

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            if (c % 300 == 0) apply_reset();
            for (int p = 0; p < 2; p++) begin
                if (done[p]) begin
                    if ($urandom_range(1, 0) == 1) new_tx(p);
                    else v[p] = 1'b0;
                end else if (v[p]) begin
                    if ($urandom_range(19, 0) == 0) v[p] = 1'b0;
                end else if ($urandom_range(2, 0) == 0) begin
                    new_tx(p);
                end
            end
            if (own >= 0) s_ready = exp_svalid() && ($urandom_range(1, 0) == 1);
            else          s_ready = 1'($urandom_range(1, 0));
            s_rdata = $urandom;
            step();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
